// File: rtl/uart_msg_check.sv
// Checks a UART byte stream against the fixed message 01,02,..,MESSAGE_LEN.
// Define UART_MSG_CHECK_TIMEOUT_EN to enable the inter-byte timeout in RECV.
module uart_msg_check #(
  parameter int MESSAGE_LEN    = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_rx_data,
  input  logic       in_rx_valid,
  output logic       out_busy,
  output logic       out_done,
  output logic       out_error,
  output logic       out_timeout,
  output logic [3:0] out_cursor,
  output logic [7:0] out_bad_byte,
  output logic [7:0] out_checksum
);

  typedef enum logic [1:0] {IDLE, RECV, DONE, ERROR} state_t;

  state_t     state_q, state_d;
  logic [4:0] cur_q, cur_d;   // one extra bit so cursor can reach MESSAGE_LEN
  logic [7:0] bad_q, bad_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] exp_byte;
  logic       last_byte;
  logic       tmo_hit;

  assign exp_byte  = 8'(cur_q) + 8'd1;
  assign last_byte = (cur_q == 5'(MESSAGE_LEN - 1));

`ifdef UART_MSG_CHECK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt_q;
  logic          tmo_q, tmo_d;

  // Idle clocks spent in RECV since the last accepted byte.
  always_ff @(posedge clk) begin
    if (!rst_n || state_q != RECV || in_rx_valid) cnt_q <= '0;
    else if (!tmo_hit)                             cnt_q <= cnt_q + 1'b1;
  end

  assign tmo_hit = (cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) tmo_q <= 1'b0;
    else        tmo_q <= tmo_d;
  end

  assign out_timeout = tmo_q;
`else
  assign tmo_hit     = 1'b0;
  assign out_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    bad_d   = bad_q;
    sum_d   = sum_q;
`ifdef UART_MSG_CHECK_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE, RECV: begin
        // A strobe always wins over a timeout landing on the same edge.
        if (in_rx_valid) begin
          sum_d = sum_q + in_rx_data;
          if (in_rx_data == exp_byte) begin
            cur_d   = cur_q + 5'd1;
            state_d = last_byte ? DONE : RECV;
          end else begin
            state_d = ERROR;
            bad_d   = in_rx_data;
          end
        end else if (state_q == RECV && tmo_hit) begin
          state_d = ERROR;
          bad_d   = 8'd0;
`ifdef UART_MSG_CHECK_TIMEOUT_EN
          tmo_d   = 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      bad_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      bad_q   <= bad_d;
      sum_q   <= sum_d;
    end
  end

  assign out_busy     = (state_q == RECV);
  assign out_done     = (state_q == DONE);
  assign out_error    = (state_q == ERROR);
  assign out_cursor   = cur_q[3:0];
  assign out_bad_byte = bad_q;
  assign out_checksum = sum_q;

endmodule
